// File: rtl/mips_dbg_pkg.sv
// Shared types and frame layout constants for the pipeline debug dumper.
package mips_dbg_pkg;

    typedef enum logic [2:0] {IDLE, HDR, PC, REG, MEM, CSUM} dbg_state_e;

    localparam logic [7:0] DBG_HDR       = 8'hA5;
    localparam int         FRAME_LEN     = 172;
    localparam int         NUM_REGS      = 32;
    localparam int         NUM_MEM_WORDS = 10;
    localparam int         PC_W          = 10;

    // First frame index of each section
    localparam logic [7:0] PC_START   = 8'd1;
    localparam logic [7:0] REG_START  = 8'd3;
    localparam logic [7:0] MEM_START  = 8'd131;
    localparam logic [7:0] CSUM_START = 8'd171;

endpackage

// File: rtl/dbg_byte_sel.sv
// Maps a frame byte index onto the captured snapshot (header, PC, registers, memory).
// The checksum byte is not handled here; the caller substitutes its accumulator.
module dbg_byte_sel
    import mips_dbg_pkg::*;
(
    input  logic [7:0]                    idx_i,
    input  logic [PC_W-1:0]               pc_i,
    input  logic [NUM_REGS*32-1:0]        regs_i,
    input  logic [NUM_MEM_WORDS*32-1:0]   mem_i,
    output logic [7:0]                    byte_o
);

    logic [6:0] regOff;
    logic [5:0] memOff;

    // Word = offset/4, byte-in-word = offset%4 sent MSB first, so lane = 3 - (offset%4)
    always_comb begin
        regOff = 7'(idx_i - REG_START);
        memOff = 6'(idx_i - MEM_START);
        byte_o = 8'h00;
        if (idx_i < PC_START) begin
            byte_o = DBG_HDR;
        end else if (idx_i == PC_START) begin
            byte_o = {{(16-PC_W){1'b0}}, pc_i[PC_W-1:8]};
        end else if (idx_i < REG_START) begin
            byte_o = pc_i[7:0];
        end else if (idx_i < MEM_START) begin
            byte_o = regs_i[{regOff[6:2], ~regOff[1:0], 3'b000} +: 8];
        end else if (idx_i < CSUM_START) begin
            byte_o = mem_i[{memOff[5:2], ~memOff[1:0], 3'b000} +: 8];
        end
    end

endmodule

// File: rtl/pipe_debug_dumper.sv
// Snapshots PC, register file and data memory on request and streams them as a
// 172-byte checksummed frame over a valid/ready byte interface.
module pipe_debug_dumper
    import mips_dbg_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          dump_req,
    input  logic [PC_W-1:0]               pc_in,
    input  logic [NUM_REGS*32-1:0]        registers_in,
    input  logic [NUM_MEM_WORDS*32-1:0]   memorias_in,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic                          busy,
    output logic                          done
);

    dbg_state_e state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] csum_q, csum_d;
    logic       done_q, done_d;
    logic       capture;
    logic       xfer;
    logic [7:0] selByte;

    logic [PC_W-1:0]             snapPc_q;
    logic [NUM_REGS*32-1:0]      snapRegs_q;
    logic [NUM_MEM_WORDS*32-1:0] snapMem_q;

    dbg_byte_sel u_byteSel (
        .idx_i  (idx_q),
        .pc_i   (snapPc_q),
        .regs_i (snapRegs_q),
        .mem_i  (snapMem_q),
        .byte_o (selByte)
    );

    assign busy     = (state_q != IDLE);
    assign tx_valid = busy;
    assign tx_data  = (state_q == IDLE) ? 8'h00 :
                      (state_q == CSUM) ? csum_q : selByte;
    assign done     = done_q;
    assign xfer     = tx_valid && tx_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        done_d  = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dump_req) begin
                    state_d = HDR;
                    idx_d   = 8'd0;
                    csum_d  = 8'd0;
                    capture = 1'b1;
                end
            end
            HDR: begin
                if (xfer) begin
                    state_d = PC;
                    idx_d   = idx_q + 8'd1;
                end
            end
            PC: begin
                if (xfer) begin
                    idx_d  = idx_q + 8'd1;
                    csum_d = csum_q + selByte;
                    if (idx_q == REG_START - 8'd1) state_d = REG;
                end
            end
            REG: begin
                if (xfer) begin
                    idx_d  = idx_q + 8'd1;
                    csum_d = csum_q + selByte;
                    if (idx_q == MEM_START - 8'd1) state_d = MEM;
                end
            end
            MEM: begin
                if (xfer) begin
                    idx_d  = idx_q + 8'd1;
                    csum_d = csum_q + selByte;
                    if (idx_q == CSUM_START - 8'd1) state_d = CSUM;
                end
            end
            CSUM: begin
                if (xfer) begin
                    state_d = IDLE;
                    idx_d   = 8'd0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shadow registers load only on an accepted request, so the frame is immune to later input changes
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= 8'd0;
            csum_q     <= 8'd0;
            done_q     <= 1'b0;
            snapPc_q   <= '0;
            snapRegs_q <= '0;
            snapMem_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            done_q  <= done_d;
            if (capture) begin
                snapPc_q   <= pc_in;
                snapRegs_q <= registers_in;
                snapMem_q  <= memorias_in;
            end
        end
    end

endmodule

// File: tb/tb_pipe_debug_dumper.sv
// Scoreboard bench for pipe_debug_dumper: stimulus pushes expected frames, a
// negedge monitor pops and compares every transferred byte.
module tb_pipe_debug_dumper;

    logic          clk = 1'b0;
    logic          reset;
    logic          dump_req;
    logic [9:0]    pc_in;
    logic [1023:0] registers_in;
    logic [319:0]  memorias_in;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          busy;
    logic          done;

    typedef struct {
        logic [7:0] data;
        int         idx;
    } exp_t;

    exp_t       expQ[$];
    logic [7:0] obs [0:171];
    int         nCompared   = 0;
    int         nMismatched = 0;
    bit         randomReady = 1'b0;
    bit         doneNext    = 1'b0;
    bit         stallPrev   = 1'b0;
    logic [7:0] prevData    = 8'h00;

    pipe_debug_dumper dut (
        .clk          (clk),
        .reset        (reset),
        .dump_req     (dump_req),
        .pc_in        (pc_in),
        .registers_in (registers_in),
        .memorias_in  (memorias_in),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        nCompared++;
        if (act !== req) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Called #1 after a posedge with the DUT idle (or in its done cycle); returns #1 after the capture edge
    task automatic applyStimulus(input logic [9:0] pc, input logic [1023:0] regs, input logic [319:0] mems);
        logic [7:0] frame [0:171];
        logic [7:0] sum;
        pc_in        = pc;
        registers_in = regs;
        memorias_in  = mems;
        dump_req     = 1'b1;
        @(posedge clk);
        #1;
        dump_req = 1'b0;
        frame[0] = 8'hA5;
        frame[1] = {6'b0, pc[9:8]};
        frame[2] = pc[7:0];
        for (int r = 0; r < 32; r++)
            for (int b = 0; b < 4; b++)
                frame[3 + 4*r + b] = regs[32*r + 24 - 8*b +: 8];
        for (int w = 0; w < 10; w++)
            for (int b = 0; b < 4; b++)
                frame[131 + 4*w + b] = mems[32*w + 24 - 8*b +: 8];
        sum = 8'h00;
        for (int k = 1; k <= 170; k++) sum = sum + frame[k];
        frame[171] = sum;
        for (int k = 0; k < 172; k++) expQ.push_back('{data: frame[k], idx: k});
    endtask

    task automatic waitDone(output int cyc);
        cyc = 0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) return;
        end
        checkOutput("done_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: a byte with valid&&ready at the negedge transfers on the following posedge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                doneNext  = 1'b0;
                stallPrev = 1'b0;
            end else begin
                checkOutput("busy", 32'(busy), 32'(expQ.size() != 0));
                if (doneNext || done) checkOutput("done_pulse", 32'(done), 32'(doneNext));
                doneNext = 1'b0;
                if (stallPrev) begin
                    checkOutput("hold_valid", 32'(tx_valid), 32'd1);
                    checkOutput("hold_data", 32'(tx_data), 32'(prevData));
                end
                if (tx_valid && tx_ready) begin
                    if (expQ.size() == 0) begin
                        checkOutput("extra_byte", 32'(tx_data), 32'hFFFF_FFFF);
                    end else begin
                        e = expQ.pop_front();
                        obs[e.idx] = tx_data;
                        checkOutput($sformatf("byte%0d", e.idx), 32'(tx_data), 32'(e.data));
                        if (e.idx == 171) doneNext = 1'b1;
                    end
                end
                stallPrev = tx_valid && !tx_ready;
                prevData  = tx_data;
            end
        end
    end

    initial begin
        int            cyc;
        logic [1023:0] regs;
        logic [319:0]  mems;

        reset        = 1'b1;
        dump_req     = 1'b1;
        pc_in        = 10'h155;
        registers_in = '1;
        memorias_in  = '1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_valid", 32'(tx_valid), 32'd0);
        checkOutput("rst_data", 32'(tx_data), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        reset    = 1'b0;
        dump_req = 1'b0;
        @(posedge clk);
        #1;

        // All-zero snapshot; done lands in cycle 173 counting the request cycle as cycle 0
        applyStimulus(10'h000, '0, '0);
        waitDone(cyc);
        checkOutput("done_cycle", 32'(cyc + 1), 32'd173);
        checkOutput("zero_hdr", 32'(obs[0]), 32'hA5);
        checkOutput("zero_csum", 32'(obs[171]), 32'h00);

        // Issued in the done cycle, so it must be accepted back-to-back
        applyStimulus(10'h3FF, '0, '0);
        waitDone(cyc);
        checkOutput("b2b_latency", 32'(cyc + 1), 32'd173);
        checkOutput("pc_hi", 32'(obs[1]), 32'h03);
        checkOutput("pc_lo", 32'(obs[2]), 32'hFF);
        checkOutput("pc_csum", 32'(obs[171]), 32'h02);

        regs = '0;
        regs[63:32] = 32'h1234_5678;
        applyStimulus(10'h000, regs, '0);
        waitDone(cyc);
        checkOutput("reg1_b0", 32'(obs[7]), 32'h12);
        checkOutput("reg1_b1", 32'(obs[8]), 32'h34);
        checkOutput("reg1_b2", 32'(obs[9]), 32'h56);
        checkOutput("reg1_b3", 32'(obs[10]), 32'h78);
        checkOutput("reg1_csum", 32'(obs[171]), 32'h14);

        mems = '0;
        mems[319:288] = 32'hFFFF_FFFF;
        applyStimulus(10'h000, '0, mems);
        waitDone(cyc);
        for (int k = 167; k <= 170; k++) checkOutput($sformatf("mem9_b%0d", k), 32'(obs[k]), 32'hFF);
        checkOutput("mem9_csum", 32'(obs[171]), 32'hFC);

        // Random backpressure with inputs scrambled after capture
        for (int r = 0; r < 32; r++) regs[32*r +: 32] = {8'(r) + 8'h11, 8'hC3, ~8'(r), 8'h5A};
        for (int w = 0; w < 10; w++) mems[32*w +: 32] = 32'hDEAD_0000 | 32'(w * 7);
        randomReady = 1'b1;
        applyStimulus(10'h2A7, regs, mems);
        pc_in        = 10'h0C3;
        registers_in = ~regs;
        memorias_in  = ~mems;
        waitDone(cyc);
        randomReady = 1'b0;
        checkOutput("rand_left", 32'(expQ.size()), 32'd0);

        @(posedge clk);
        #1;
        // Second request at byte 50 must be ignored, reset at byte 80 aborts
        applyStimulus(10'h1E1, regs, mems);
        repeat (50) @(posedge clk);
        #1;
        pc_in        = 10'h155;
        registers_in = ~regs;
        dump_req     = 1'b1;
        @(posedge clk);
        #1;
        dump_req = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        expQ.delete();
        reset = 1'b0;
        checkOutput("abort_valid", 32'(tx_valid), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("abort_done", 32'(done), 32'd0);

        applyStimulus(10'h2A7, regs, mems);
        waitDone(cyc);
        checkOutput("restart_hdr", 32'(obs[0]), 32'hA5);
        checkOutput("restart_latency", 32'(cyc + 1), 32'd173);

        repeat (5) @(posedge clk);
        #1;
        checkOutput("final_left", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/pipe_debug_dumper.md
PIPE_DEBUG_DUMPER -- requirements
Module: pipe_debug_dumper

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset, sampled on rising clk.
REQ-003 SHALL have port dump_req, input, 1, request to snapshot and transmit pipeline state.
REQ-004 SHALL have port pc_in, input, 10, current pipeline PC (same width as pipeline PC).
REQ-005 SHALL have port registers_in, input, 1024, flattened register file; reg i = bits [32i+31:32i].
REQ-006 SHALL have port memorias_in, input, 320, flattened data memory; word j = bits [32j+31:32j], j = 0..9.
REQ-007 SHALL have port tx_data, output, 8, current frame byte.
REQ-008 SHALL have port tx_valid, output, 1, tx_data holds a byte offered to the consumer.
REQ-009 SHALL have port tx_ready, input, 1, consumer (UART transmitter) accepts the byte this cycle.
REQ-010 SHALL have port busy, output, 1, a frame is in progress.
REQ-011 SHALL have port done, output, 1, one-cycle pulse after the last byte is accepted.

Function
REQ-012 SHALL capture pc_in, registers_in and memorias_in into shadow registers on the rising edge where dump_req=1 and the FSM is in IDLE.
REQ-013 SHALL ignore dump_req while busy=1; no queuing, and the snapshot stays unchanged.
REQ-014 SHALL transmit a 172-byte frame: index 0 = 0xA5; 1..2 = PC zero-extended to 16 bits, MSB first; 3..130 = reg0..reg31, 4 bytes each, MSB first; 131..170 = mem word 0..9, 4 bytes each, MSB first; 171 = checksum.
REQ-015 SHALL compute checksum as the modulo-256 sum of frame bytes 1..170. The header is excluded.
REQ-016 SHALL use FSM states IDLE, HDR, PC, REG, MEM, CSUM. Transitions: IDLE->HDR on accepted dump_req. HDR->PC, PC->REG, REG->MEM, MEM->CSUM, each after that section's final byte transfers. CSUM->IDLE on checksum transfer.
REQ-017 SHALL count a byte as transferred only in a cycle where tx_valid=1 and tx_ready=1. The byte index advances by exactly 1 per transfer.
REQ-018 SHALL hold tx_data stable and tx_valid high until the byte transfers. tx_valid SHALL NOT drop mid-frame.
REQ-019 SHALL assert tx_valid with byte 0 in the cycle after dump_req is captured. With tx_ready held high, it SHALL deliver one byte per cycle, with no bubbles between sections.
REQ-020 SHALL hold busy=1 from the first cycle of HDR through the cycle the checksum transfers. busy SHALL be 0 in IDLE.
REQ-021 SHALL pulse done=1 for exactly one cycle, in the cycle after the checksum transfer. A new dump_req is accepted in that same cycle.
REQ-022 SHALL accumulate the checksum incrementally on each transfer in PC/REG/MEM. The accumulator SHALL clear on frame start.

Reset
REQ-023 On reset=1, the block SHALL enter IDLE and set tx_valid=0, tx_data=0x00, busy=0, done=0, byte index=0, checksum=0.
REQ-024 Reset mid-frame SHALL abort the frame: no done pulse, and the next dump_req starts a fresh frame at the header.
REQ-025 reset SHALL take priority over dump_req in the same cycle.

Structure
REQ-026 Shared package mips_dbg_pkg SHALL hold: FSM state enum, DBG_HDR=8'hA5, FRAME_LEN=172, NUM_REGS=32, NUM_MEM_WORDS=10, and section start indices 1, 3, 131, 171.
REQ-027 One combinational sub-module, dbg_byte_sel, SHALL map (byte index, snapshot) to a frame byte. The FSM, counters and checksum SHALL remain in pipe_debug_dumper.

Verification
REQ-028 All-zero snapshot, pc=0, tx_ready=1: frame is A5, then 170x 00, then checksum 00; done pulses in cycle 173 after dump_req.
REQ-029 pc_in=10'h3FF, rest zero: bytes 1..2 = 03 FF; checksum 02.
REQ-030 reg1=0x12345678, rest zero: bytes 7..10 = 12 34 56 78; checksum 14. Mem word 9=0xFFFFFFFF instead: bytes 167..170 = FF; checksum FC.
REQ-031 tx_ready toggled randomly, with inputs changed after capture: tx_data stable while tx_valid&&!tx_ready, frame matches snapshot taken at dump_req, 172 transfers exactly.
REQ-032 dump_req pulsed at byte 50, then reset asserted at byte 80: second request ignored; after reset tx_valid=0 and done never pulses; next dump_req restarts with A5.
